// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//
// Owns the single write port of the video memory and shares it between
// two requesters:
//   - the CPU pixel strobe, which can never be stalled, and
//   - a rectangle-fill engine that paints a solid colour in raster order.
// The CPU has fixed priority. In any cycle that carries a CPU write, the
// fill engine freezes its counters, so no fill pixel is lost.
//
// Ports
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   iCpuWe/X/Y/Color      CPU single-pixel write (1-cycle latency to oWe)
//   iFillReq              fill start, sampled only while idle
//   iFillX0/Y0/W/H/Color  rectangle origin, size (0..2^COORD_WIDTH) and colour
//   oFillBusy             fill engine in FILL or DONE
//   oFillDone             one-cycle completion pulse
//   oWe/oWriteAddress/oDataIn  registered video RAM write port, address {col,row}
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iFillReq; only CPU writes reach the RAM
// FILL  | issuing one pixel (or one clip-skip) per cycle without a CPU write
// DONE  | one-cycle completion; oFillDone high; back to IDLE next

module vram_write_scheduler #(
    parameter int COORD_WIDTH = 8,
    parameter int COLOR_WIDTH = 3
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     iCpuWe,
    input  logic [COORD_WIDTH-1:0]   iCpuX,
    input  logic [COORD_WIDTH-1:0]   iCpuY,
    input  logic [COLOR_WIDTH-1:0]   iCpuColor,
    input  logic                     iFillReq,
    input  logic [COORD_WIDTH-1:0]   iFillX0,
    input  logic [COORD_WIDTH-1:0]   iFillY0,
    input  logic [COORD_WIDTH:0]     iFillW,
    input  logic [COORD_WIDTH:0]     iFillH,
    input  logic [COLOR_WIDTH-1:0]   iFillColor,
    output logic                     oFillBusy,
    output logic                     oFillDone,
    output logic                     oWe,
    output logic [2*COORD_WIDTH-1:0] oWriteAddress,
    output logic [COLOR_WIDTH-1:0]   oDataIn
);

    localparam logic [COORD_WIDTH:0] ONE  = {{COORD_WIDTH{1'b0}}, 1'b1};
    localparam logic [COORD_WIDTH:0] ZERO = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COORD_WIDTH-1:0]   x0_q, x0_d;
    logic [COORD_WIDTH-1:0]   y0_q, y0_d;
    logic [COORD_WIDTH:0]     w_q, w_d;
    logic [COORD_WIDTH:0]     h_q, h_d;
    logic [COLOR_WIDTH-1:0]   color_q, color_d;
    logic [COORD_WIDTH:0]     col_q, col_d;
    logic [COORD_WIDTH:0]     row_q, row_d;

    logic                     we_q, we_d;
    logic [2*COORD_WIDTH-1:0] addr_q, addr_d;
    logic [COLOR_WIDTH-1:0]   data_q, data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    // One extra bit on the sums so a pixel past the screen edge shows up
    // as the MSB instead of wrapping back to coordinate 0.
    logic [COORD_WIDTH:0] x_sum;
    logic [COORD_WIDTH:0] y_sum;
    logic                 col_last;
    logic                 row_last;

    always_comb begin
        x_sum    = {1'b0, x0_q} + col_q;
        y_sum    = {1'b0, y0_q} + row_q;
        col_last = (col_q == (w_q - ONE));
        row_last = (row_q == (h_q - ONE));
    end

    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        color_d = color_q;
        col_d   = col_q;
        row_d   = row_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;

        // CPU write always takes the port in the very next cycle.
        if (iCpuWe) begin
            we_d   = 1'b1;
            addr_d = {iCpuX, iCpuY};
            data_d = iCpuColor;
        end

        case (state_q)
            IDLE: begin
                if (iFillReq) begin
                    x0_d    = iFillX0;
                    y0_d    = iFillY0;
                    w_d     = iFillW;
                    h_d     = iFillH;
                    color_d = iFillColor;
                    col_d   = ZERO;
                    row_d   = ZERO;
                    if ((iFillW == ZERO) || (iFillH == ZERO)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                if (!iCpuWe) begin
                    if (y_sum[COORD_WIDTH]) begin
                        // Row below the screen: nothing further can be drawn.
                        state_d = DONE;
                    end else if (x_sum[COORD_WIDTH]) begin
                        // Rest of this row is off-screen; spend the cycle skipping it.
                        col_d = ZERO;
                        if (row_last) begin
                            state_d = DONE;
                        end else begin
                            row_d = row_q + ONE;
                        end
                    end else begin
                        we_d   = 1'b1;
                        addr_d = {x_sum[COORD_WIDTH-1:0], y_sum[COORD_WIDTH-1:0]};
                        data_d = color_q;
                        if (col_last) begin
                            col_d = ZERO;
                            if (row_last) begin
                                state_d = DONE;
                            end else begin
                                row_d = row_q + ONE;
                            end
                        end else begin
                            col_d = col_q + ONE;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            col_q   <= '0;
            row_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            col_q   <= col_d;
            row_q   <= row_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign oWe           = we_q;
    assign oWriteAddress = addr_q;
    assign oDataIn       = data_q;
    assign oFillBusy     = busy_q;
    assign oFillDone     = done_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: a vector table (inputs applied
// before an edge, outputs expected after it) plus hand-written reset
// sequences.

module tb_vram_write_scheduler;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iCpuWe;
    logic [7:0]  iCpuX, iCpuY;
    logic [2:0]  iCpuColor;
    logic        iFillReq;
    logic [7:0]  iFillX0, iFillY0;
    logic [8:0]  iFillW, iFillH;
    logic [2:0]  iFillColor;
    logic        oFillBusy, oFillDone, oWe;
    logic [15:0] oWriteAddress;
    logic [2:0]  oDataIn;

    int checks = 0;
    int errors = 0;

    vram_write_scheduler #(.COORD_WIDTH(8), .COLOR_WIDTH(3)) dut (
        .Clock(Clock), .Reset(Reset),
        .iCpuWe(iCpuWe), .iCpuX(iCpuX), .iCpuY(iCpuY), .iCpuColor(iCpuColor),
        .iFillReq(iFillReq), .iFillX0(iFillX0), .iFillY0(iFillY0),
        .iFillW(iFillW), .iFillH(iFillH), .iFillColor(iFillColor),
        .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oWe(oWe),
        .oWriteAddress(oWriteAddress), .oDataIn(oDataIn)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic       cwe;
        logic [7:0] cx, cy;
        logic [2:0] cc;
        logic       req;
        logic [7:0] x0, y0;
        logic [8:0] w, h;
        logic [2:0] fc;
        logic       e_we;
        logic [7:0] e_ax, e_ay;
        logic [2:0] e_d;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic cwe, input logic [7:0] cx, input logic [7:0] cy, input logic [2:0] cc,
        input logic req, input logic [7:0] x0, input logic [7:0] y0,
        input logic [8:0] w, input logic [8:0] h, input logic [2:0] fc,
        input logic e_we, input logic [7:0] e_ax, input logic [7:0] e_ay, input logic [2:0] e_d,
        input logic e_busy, input logic e_done);
        vec_t v;
        v.cwe = cwe; v.cx = cx; v.cy = cy; v.cc = cc;
        v.req = req; v.x0 = x0; v.y0 = y0; v.w = w; v.h = h; v.fc = fc;
        v.e_we = e_we; v.e_ax = e_ax; v.e_ay = e_ay; v.e_d = e_d;
        v.e_busy = e_busy; v.e_done = e_done;
        return v;
    endfunction

    // No CPU, no request; expect a fill/CPU write or nothing.
    function automatic vec_t nop(input logic we, input logic [7:0] ax, input logic [7:0] ay,
                                 input logic [2:0] d, input logic busy, input logic done);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, we, ax, ay, d, busy, done);
    endfunction

    function automatic vec_t req(input logic [7:0] x0, input logic [7:0] y0,
                                 input logic [8:0] w, input logic [8:0] h, input logic [2:0] fc,
                                 input logic busy, input logic done);
        return mk(0, 0, 0, 0, 1, x0, y0, w, h, fc, 0, 0, 0, 0, busy, done);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        iCpuWe = v.cwe; iCpuX = v.cx; iCpuY = v.cy; iCpuColor = v.cc;
        iFillReq = v.req; iFillX0 = v.x0; iFillY0 = v.y0;
        iFillW = v.w; iFillH = v.h; iFillColor = v.fc;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        vec_t idle_v;
        idle_v = nop(0, 0, 0, 0, 0, 0);
        drive(idle_v);
        Reset = 1'b1;
        tick();
        tick();
        chk("reset_we",   {31'b0, oWe}, 32'd0);
        chk("reset_addr", {16'b0, oWriteAddress}, 32'd0);
        chk("reset_data", {29'b0, oDataIn}, 32'd0);
        chk("reset_busy", {31'b0, oFillBusy}, 32'd0);
        chk("reset_done", {31'b0, oFillDone}, 32'd0);
        Reset = 1'b0;

        // CPU writes while idle
        vecs.push_back(mk(1, 5, 6, 3, 0, 0, 0, 0, 0, 0, 1, 5, 6, 3, 0, 0));
        vecs.push_back(mk(1, 255, 0, 7, 0, 0, 0, 0, 0, 0, 1, 255, 0, 7, 0, 0));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0));
        // Basic 3x2 fill; new requests during FILL/DONE are ignored
        vecs.push_back(req(10, 20, 3, 2, 5, 1, 0));
        vecs.push_back(nop(1, 10, 20, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 99, 99, 1, 1, 2, 1, 11, 20, 5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 99, 99, 1, 1, 2, 1, 12, 20, 5, 1, 0));
        vecs.push_back(nop(1, 10, 21, 5, 1, 0));
        vecs.push_back(nop(1, 11, 21, 5, 1, 0));
        vecs.push_back(nop(1, 12, 21, 5, 1, 1));
        vecs.push_back(req(40, 50, 1, 1, 6, 0, 0));     // applied in DONE: ignored
        vecs.push_back(req(40, 50, 1, 1, 6, 1, 0));     // applied in IDLE: accepted
        vecs.push_back(nop(1, 40, 50, 6, 1, 1));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0));
        // Contention: CPU takes the slot of the 2nd fill pixel
        vecs.push_back(req(10, 20, 3, 2, 5, 1, 0));
        vecs.push_back(nop(1, 10, 20, 5, 1, 0));
        vecs.push_back(mk(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 1, 0));
        vecs.push_back(nop(1, 11, 20, 5, 1, 0));
        vecs.push_back(nop(1, 12, 20, 5, 1, 0));
        vecs.push_back(nop(1, 10, 21, 5, 1, 0));
        vecs.push_back(nop(1, 11, 21, 5, 1, 0));
        vecs.push_back(nop(1, 12, 21, 5, 1, 1));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0));
        // Clipping at the bottom-right corner
        vecs.push_back(req(254, 255, 4, 3, 2, 1, 0));
        vecs.push_back(nop(1, 254, 255, 2, 1, 0));
        vecs.push_back(nop(1, 255, 255, 2, 1, 0));
        vecs.push_back(nop(0, 0, 0, 0, 1, 0));          // x clip skip
        vecs.push_back(nop(0, 0, 0, 0, 1, 1));          // y clip ends fill
        vecs.push_back(nop(0, 0, 0, 0, 0, 0));
        // Empty fills
        vecs.push_back(req(1, 1, 0, 5, 4, 1, 1));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0));
        vecs.push_back(req(1, 1, 3, 0, 4, 1, 1));
        vecs.push_back(nop(0, 0, 0, 0, 0, 0));
        // Full-width single row: col runs to 255 then wraps to the end
        vecs.push_back(req(0, 9, 256, 1, 1, 1, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            tick();
            chk($sformatf("v%0d_we", i),   {31'b0, oWe},       {31'b0, vecs[i].e_we});
            chk($sformatf("v%0d_busy", i), {31'b0, oFillBusy}, {31'b0, vecs[i].e_busy});
            chk($sformatf("v%0d_done", i), {31'b0, oFillDone}, {31'b0, vecs[i].e_done});
            if (vecs[i].e_we) begin
                chk($sformatf("v%0d_addr", i), {16'b0, oWriteAddress},
                    {16'b0, vecs[i].e_ax, vecs[i].e_ay});
                chk($sformatf("v%0d_data", i), {29'b0, oDataIn}, {29'b0, vecs[i].e_d});
            end
        end

        // Remaining 256 pixels of the full-width row
        drive(idle_v);
        for (int c = 0; c < 256; c++) begin
            tick();
            chk("row256_we",   {31'b0, oWe}, 32'd1);
            chk("row256_addr", {16'b0, oWriteAddress}, {16'b0, c[7:0], 8'd9});
            chk("row256_done", {31'b0, oFillDone}, {31'b0, (c == 255)});
        end
        tick();
        chk("row256_idle", {31'b0, oFillBusy}, 32'd0);

        // Reset in the middle of a 4x4 fill
        drive(req(0, 0, 4, 4, 1, 0, 0));
        tick();
        drive(idle_v);
        tick();
        tick();
        tick();
        chk("mid_third_we",   {31'b0, oWe}, 32'd1);
        chk("mid_third_addr", {16'b0, oWriteAddress}, {16'b0, 8'd2, 8'd0});
        Reset = 1'b1;
        tick();
        chk("mid_rst_we",   {31'b0, oWe}, 32'd0);
        chk("mid_rst_busy", {31'b0, oFillBusy}, 32'd0);
        chk("mid_rst_done", {31'b0, oFillDone}, 32'd0);
        Reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("mid_after_we",   {31'b0, oWe}, 32'd0);
            chk("mid_after_done", {31'b0, oFillDone}, 32'd0);
        end
        drive(req(7, 8, 1, 1, 3, 0, 0));
        tick();
        chk("mid_idle_accept", {31'b0, oFillBusy}, 32'd1);
        drive(idle_v);
        tick();
        chk("mid_idle_we",   {31'b0, oWe}, 32'd1);
        chk("mid_idle_addr", {16'b0, oWriteAddress}, {16'b0, 8'd7, 8'd8});
        chk("mid_idle_done", {31'b0, oFillDone}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Owns the single write port of the 256x256x3 video memory. Shares it between two requesters: the CPU `VGA` instruction (single-pixel strobe, cannot stall) and a hardware rectangle-fill engine.
- The fill engine paints a solid colour rectangle in raster order so the game can clear and redraw mole cells without long instruction loops.
- Sits between the MiniAlu decode stage and the video RAM write inputs (address is {column,row}).

Parameters:
- COORD_WIDTH, 8, bits per coordinate; the screen is 2^COORD_WIDTH pixels per side.
- COLOR_WIDTH, 3, pixel colour bits (R,G,B).

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iCpuWe  in  1  CPU pixel write strobe, one cycle per pixel.
- iCpuX  in  COORD_WIDTH  CPU pixel column.
- iCpuY  in  COORD_WIDTH  CPU pixel row.
- iCpuColor  in  COLOR_WIDTH  CPU pixel colour.
- iFillReq  in  1  start-fill pulse or level, sampled only in IDLE.
- iFillX0  in  COORD_WIDTH  rectangle left column.
- iFillY0  in  COORD_WIDTH  rectangle top row.
- iFillW  in  COORD_WIDTH+1  width in pixels, 0..256.
- iFillH  in  COORD_WIDTH+1  height in pixels, 0..256.
- iFillColor  in  COLOR_WIDTH  fill colour.
- oFillBusy  out  1  high while state is FILL or DONE.
- oFillDone  out  1  one-cycle completion pulse.
- oWe  out  1  video RAM write enable (registered).
- oWriteAddress  out  2*COORD_WIDTH  {column,row} (registered).
- oDataIn  out  COLOR_WIDTH  pixel colour (registered).

Behaviour:
- Reset sets: state IDLE; oWe=0, oWriteAddress=0, oDataIn=0, oFillBusy=0, oFillDone=0; counters cleared.
- Reset during FILL aborts the fill: no further writes and no oFillDone pulse.
- All outputs are registered. A write decided at edge N is visible on oWe/oWriteAddress/oDataIn during cycle N..N+1.
- CPU path latency is 1 cycle: iCpuWe at edge N gives oWe=1 with {iCpuX,iCpuY,iCpuColor} after edge N.
- Arbitration is fixed priority, CPU wins. In any cycle with iCpuWe=1 the fill engine does not advance: it holds its counters and loses no pixel. CPU writes are never dropped or delayed.
- FSM states: IDLE, FILL, DONE.
- IDLE:
  - iFillReq=1 latches X0, Y0, W, H and colour, and clears col/row counters.
  - If W=0 or H=0 go to DONE with no writes; otherwise go to FILL.
  - iFillReq is ignored outside IDLE; parameter inputs are don't-care after latch.
- FILL: on each edge without a CPU write, issue pixel (X0+col, Y0+row), then advance.
  - col increments first; at col=W-1, col wraps to 0 and row increments.
  - Issuing pixel col=W-1, row=H-1 moves the FSM to DONE.
- Clipping: sums use COORD_WIDTH+1 bits.
  - If X0+col exceeds 2^COORD_WIDTH-1, the rest of the row is skipped: col=0, row++ in that same cycle, with no write.
  - If Y0+row exceeds the maximum, the fill ends: go to DONE with no write.
  - A skip cycle consumes one cycle but performs no write.
  - Addresses never wrap.
- DONE lasts exactly one cycle. oFillDone=1 there, and oWe may show the final fill pixel in that same cycle. Next state is IDLE.
- iFillReq held high during DONE is not accepted until the next cycle, which is in IDLE.
- Unclipped fill with no contention: request accepted at edge N; W*H writes follow on consecutive cycles; oFillDone coincides with the last write.

Test Plan:
- Reset mid-run: start a 4x4 fill, assert Reset at the third write → oWe=0 and oFillBusy=0 the next cycle; no oFillDone; the state is IDLE.
- Basic fill: X0=10, Y0=20, W=3, H=2, colour=3'b101, no CPU traffic → 6 consecutive writes to {10,20},{11,20},{12,20},{10,21},{11,21},{12,21}. oFillDone is high with the 6th write and oFillBusy falls the cycle after.
- Contention: CPU writes (0,0) colour 3'b111 in the cycle the fill would issue its 2nd pixel of the 3x2 fill → CPU write appears first, fill resumes with {11,20}, 7 total writes, no pixel missing.
- Clipping: X0=254, Y0=255, W=4, H=3 → only {254,255} and {255,255} are written; then oFillDone pulses; no address wraps to 0.
- Empty fill: W=0, H=5 → no oWe; oFillBusy high for one cycle; oFillDone pulses one cycle after acceptance.
- Request while busy: pulse iFillReq with new parameters during an active fill → ignored; only the original rectangle is written.
